yarp_data_mem_resp: RTL

Memory-side responder for the core's data-memory request interface. It accepts a load/store request with address, size and write data, and models a word-organised SRAM with a configurable access latency. It performs byte-lane steering for sub-word writes. Read data is returned LSB-aligned and unextended; the core's load path applies sign or zero extension. It sits between the core's data-memory port and the testbench/SoC, and also serves as the reference data RAM for simulation.

---
 rtl/yarp_data_mem_resp.sv | 123 ++++++++++++
 1 files changed

// File: rtl/yarp_data_mem_resp.sv
// rtl/yarp_data_mem_resp.sv - data-memory responder: word SRAM model with fixed latency and byte-lane steering
module yarp_data_mem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic        mem_gnt_o,
    output logic        mem_rsp_valid_o,
    output logic [31:0] mem_rd_data_o,
    output logic        mem_err_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];

    logic             access;
    logic             acc_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      rd_result;
    logic [3:0]       lane_mask;
    logic [31:0]      lane_data;

    assign mem_gnt_o = (state == IDLE);

    always_comb begin
        next_state = state;
        access     = 1'b0;
        case (state)
            IDLE: if (data_mem_req_i) next_state = WAIT;
            WAIT: if (count == 4'd0) begin
                access     = 1'b1;
                next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Access decode works purely off the latched request so inputs may change during WAIT.
    always_comb begin
        word_idx  = addr_q[IDX_W+1:2];
        acc_err   = (size_q == 2'b10)
                  | ((size_q == 2'b01) & addr_q[0])
                  | ((size_q == 2'b11) & (addr_q[1:0] != 2'b00))
                  | ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
        rd_word   = mem[word_idx];
        rd_shift  = rd_word >> {addr_q[1:0], 3'b000};
        rd_result = 32'd0;
        lane_mask = 4'b1111;
        case (size_q)
            2'b00: begin
                rd_result = rd_shift & 32'h0000_00FF;
                lane_mask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                rd_result = rd_shift & 32'h0000_FFFF;
                lane_mask = 4'b0011 << addr_q[1:0];
            end
            default: begin
                rd_result = rd_shift;
                lane_mask = 4'b1111;
            end
        endcase
        lane_data = wdata_q << {addr_q[1:0], 3'b000};
        if (acc_err || wr_q) rd_result = 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            count           <= 4'd0;
            mem_rsp_valid_o <= 1'b0;
            mem_rd_data_o   <= 32'd0;
            mem_err_o       <= 1'b0;
            addr_q          <= 32'd0;
            size_q          <= 2'b00;
            wr_q            <= 1'b0;
            wdata_q         <= 32'd0;
        end else begin
            state           <= next_state;
            mem_rsp_valid_o <= access;
            if (state == IDLE && data_mem_req_i) begin
                addr_q  <= data_mem_addr_i;
                size_q  <= data_mem_byte_en_i;
                wr_q    <= data_mem_wr_i;
                wdata_q <= data_mem_wr_data_i;
                count   <= 4'(LATENCY - 1);
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (access) begin
                mem_rd_data_o <= rd_result;
                mem_err_o     <= acc_err;
            end
        end
    end

    // Reset on the access edge suppresses the write as well as the response.
    always_ff @(posedge clk) begin
        if (!reset && access && wr_q && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end
endmodule
